// File: rtl/dummy_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dummy_arbiter_if
//  Brief    : Request/response channel bundle between the requesters and
//             dummy_arbiter. Master = requester side, slave = arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface dummy_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 128
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [ID_W-1:0]           rsp_id_o;
    logic [DATA_W-1:0]         rsp_data_o;

    modport master (
        output req_valid_i, req_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o
    );

    modport slave (
        input  req_valid_i, req_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o
    );
endinterface
`default_nettype wire

// File: rtl/dummy_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dummy_arbiter
//  Brief    : Round-robin front end sharing one dummy datapath between
//             NUM_REQ requesters; one transaction in flight, response
//             returned with the owning requester ID.
//  Revision : 1.0  initial release
// ============================================================================
module dummy_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 128,
    parameter int PIPE_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    dummy_arbiter_if.slave    bus,
    output logic [DATA_W-1:0] dp_data_o,
    input  logic [DATA_W-1:0] dp_data_i,
    output logic              busy_o
);
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_dp_data;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_data;

    logic               w_hi_found;
    logic               w_lo_found;
    logic [ID_W-1:0]    w_hi_idx;
    logic [ID_W-1:0]    w_lo_idx;
    logic               w_found;
    logic [ID_W-1:0]    w_gnt;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [NUM_REQ-1:0] w_req_ready;

    // Lowest valid index at/above the pointer wins; otherwise the lowest
    // valid index below it (this is the wrap-around part of the search).
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid_i[k]) begin
                if (k >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ID_W'(k);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = ID_W'(k);
                end
            end
        end
    end

    assign w_found   = w_hi_found | w_lo_found;
    assign w_gnt     = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_ptr_nxt = (int'(w_gnt) == NUM_REQ - 1) ? '0 : w_gnt + 1'b1;

    // One-hot accept, only offered while idle.
    always_comb begin
        w_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_req_ready[k] = (r_state == c_ST_IDLE) && w_found && (int'(w_gnt) == k);
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_found)           w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (r_cnt == '0)       w_state_nxt = c_ST_RESP;
            c_ST_RESP: if (bus.rsp_ready_i)   w_state_nxt = c_ST_IDLE;
            default:                          w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Grant capture, latency countdown, result capture and response hold.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_dp_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_dp_data <= bus.req_data_i[int'(w_gnt) * DATA_W +: DATA_W];
                        r_rsp_id  <= w_gnt;
                        r_cnt     <= c_CNT_W'(PIPE_LAT);
                        r_ptr     <= w_ptr_nxt;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= dp_data_i;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_id_o    = r_rsp_id;
    assign bus.rsp_data_o  = r_rsp_data;
    assign dp_data_o       = r_dp_data;
    assign busy_o          = (r_state != c_ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_dummy_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_dummy_arbiter
//  Brief    : Bench for dummy_arbiter: transaction-level reference model,
//             per-cycle compare, directed scenarios, random traffic, and a
//             second single-requester zero-latency build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dummy_arbiter;
    localparam int N   = 4;
    localparam int DW  = 128;
    localparam int LAT = 1;
    localparam logic [DW-1:0] MASK = {16{8'hA5}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- DUT A: 4 requesters, registered datapath ------------
    dummy_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus_a ();
    logic [DW-1:0] dp_o_a;
    logic [DW-1:0] dp_i_a;
    logic          busy_a;

    dummy_arbiter #(.NUM_REQ(N), .DATA_W(DW), .PIPE_LAT(LAT)) dut_a (
        .clk_i(clk), .reset_i(rst), .bus(bus_a),
        .dp_data_o(dp_o_a), .dp_data_i(dp_i_a), .busy_o(busy_a)
    );

    always @(posedge clk) dp_i_a <= dp_o_a ^ MASK;

    // ---------------- DUT B: 1 requester, combinational datapath ----------
    dummy_arbiter_if #(.NUM_REQ(1), .DATA_W(DW)) bus_b ();
    logic [DW-1:0] dp_o_b;
    logic [DW-1:0] dp_i_b;
    logic          busy_b;

    dummy_arbiter #(.NUM_REQ(1), .DATA_W(DW), .PIPE_LAT(0)) dut_b (
        .clk_i(clk), .reset_i(rst), .bus(bus_b),
        .dp_data_o(dp_o_b), .dp_data_i(dp_i_b), .busy_o(busy_b)
    );

    assign dp_i_b = dp_o_b ^ MASK;

    // ---------------- checking helpers ------------------------------------
    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) begin
            if (r < 0 && v[(ptr + i) % N]) r = (ptr + i) % N;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- transaction-level reference model -------------------
    bit            m_busy  = 1'b0;
    bit            m_rsp_v = 1'b0;
    int            m_age   = 0;
    int            m_ptr   = 0;
    int            m_id    = 0;
    int            m_gnt_now = -1;
    logic [DW-1:0] m_dp    = '0;
    logic [DW-1:0] m_rsp_d = '0;
    int            cyc     = 0;
    int            mg;
    int q_gnt[$];
    int q_gcyc[$];
    int q_rcyc[$];
    int q_hcyc[$];

    always @(posedge clk) begin
        cyc++;
        m_gnt_now = -1;
        if (rst) begin
            m_busy = 1'b0; m_rsp_v = 1'b0; m_ptr = 0; m_id = 0;
            m_dp = '0; m_rsp_d = '0;
        end else if (!m_busy) begin
            mg = pick(bus_a.req_valid_i, m_ptr);
            if (mg >= 0) begin
                m_busy = 1'b1; m_age = 0; m_id = mg;
                m_dp = bus_a.req_data_i[mg*DW +: DW];
                m_ptr = (mg + 1) % N;
                m_gnt_now = mg;
                q_gnt.push_back(mg);
                q_gcyc.push_back(cyc);
            end
        end else if (!m_rsp_v) begin
            m_age++;
            if (m_age == LAT + 1) begin
                m_rsp_v = 1'b1;
                m_rsp_d = m_dp ^ MASK;
                q_rcyc.push_back(cyc);
            end
        end else if (bus_a.rsp_ready_i) begin
            m_rsp_v = 1'b0;
            m_busy  = 1'b0;
            q_hcyc.push_back(cyc);
        end
    end

    // Per-cycle comparison of DUT A against the model.
    bit            cmp_en = 1'b0;
    int            pc;
    logic [N-1:0]  exp_rdy;

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_rdy = '0;
            if (!m_busy) begin
                pc = pick(bus_a.req_valid_i, m_ptr);
                if (pc >= 0) exp_rdy[pc] = 1'b1;
            end
            chk("req_ready", bus_a.req_ready_o, exp_rdy);
            chk("busy", busy_a, m_busy);
            chk("dp_data", dp_o_a, m_dp);
            chk("rsp_valid", bus_a.rsp_valid_o, m_rsp_v);
            chk("rsp_id", bus_a.rsp_id_o, m_id);
            chk("rsp_data", bus_a.rsp_data_o, m_rsp_d);
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    bit hold_valid = 1'b0;

    task automatic step();
        @(posedge clk);
        #2;
        if (m_gnt_now >= 0 && !hold_valid) bus_a.req_valid_i[m_gnt_now] = 1'b0;
    endtask

    task automatic set_req(input int k, input logic [DW-1:0] d);
        bus_a.req_data_i[k*DW +: DW] = d;
        bus_a.req_valid_i[k] = 1'b1;
    endtask

    task automatic clear_log();
        q_gnt.delete(); q_gcyc.delete(); q_rcyc.delete(); q_hcyc.delete();
    endtask

    task automatic wait_grants(input int n, input int budget);
        int t;
        t = 0;
        while (q_gnt.size() < n && t < budget) begin step(); t++; end
        if (q_gnt.size() < n) begin
            n_checks++; n_errors++;
            $display("FAIL grant_timeout got=%0d want=%0d", q_gnt.size(), n);
        end
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int t;
        t = 0;
        while (q_rcyc.size() < n && t < budget) begin step(); t++; end
        if (q_rcyc.size() < n) begin
            n_checks++; n_errors++;
            $display("FAIL rsp_timeout got=%0d want=%0d", q_rcyc.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (m_busy && t < budget) begin step(); t++; end
        if (m_busy) begin
            n_checks++; n_errors++;
            $display("FAIL idle_timeout got=busy exp=idle");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_log();
    endtask

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ---------------------------------------
    initial begin
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] db;
        int            exp_rr [6];

        rst = 1'b1;
        bus_a.req_valid_i = '0; bus_a.req_data_i = '0; bus_a.rsp_ready_i = 1'b0;
        bus_b.req_valid_i = '0; bus_b.req_data_i = '0; bus_b.rsp_ready_i = 1'b0;
        step();
        cmp_en = 1'b1;
        step();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_rsp_valid", bus_a.rsp_valid_o, 0);
        chk("rst_rsp_id", bus_a.rsp_id_o, 0);
        chk("rst_rsp_data", bus_a.rsp_data_o, 0);
        chk("rst_dp_data", dp_o_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_b_busy", busy_b, 0);

        // 1. Single request from requester 2.
        step();
        clear_log();
        bus_a.rsp_ready_i = 1'b1;
        set_req(2, 128'h1);
        @(negedge clk);
        chk("t1_req_ready", bus_a.req_ready_o, 4'b0100);
        wait_grants(1, 20);
        wait_rsp(1, 20);
        @(negedge clk);
        chk("t1_rsp_data", bus_a.rsp_data_o, {{15{8'hA5}}, 8'hA4});
        chk("t1_rsp_id", bus_a.rsp_id_o, 2);
        chk("t1_latency", q_rcyc[0] - q_gcyc[0], 2);
        wait_idle(20);

        // 2. Round robin with all requesters continuously valid.
        do_reset();
        bus_a.rsp_ready_i = 1'b1;
        hold_valid = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, DW'(k + 16));
        wait_grants(8, 100);
        bus_a.req_valid_i = '0;
        hold_valid = 1'b0;
        exp_rr = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6; i++) chk("t2_order", q_gnt[i], exp_rr[i]);
        for (int i = 0; i < 5; i++) chk("t2_spacing", q_gcyc[i+1] - q_gcyc[i], LAT + 3);
        chk("t2_last", q_gnt[7], 3);
        wait_idle(20);

        // 3. Wrap / fairness (pointer is 0 after the grant to 3).
        clear_log();
        set_req(1, 128'h11);
        set_req(3, 128'h33);
        wait_grants(2, 40);
        chk("t3_first", q_gnt[0], 1);
        chk("t3_second", q_gnt[1], 3);
        wait_idle(20);
        set_req(0, 128'h100);
        set_req(3, 128'h300);
        wait_grants(3, 40);
        chk("t3_wrap", q_gnt[2], 0);
        bus_a.req_valid_i[3] = 1'b0;
        wait_idle(20);

        // 4. Response backpressure with another request pending.
        clear_log();
        bus_a.rsp_ready_i = 1'b0;
        d1 = rnd128();
        d2 = rnd128();
        set_req(1, d1);
        wait_rsp(1, 20);
        set_req(2, d2);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("t4_valid", bus_a.rsp_valid_o, 1);
            chk("t4_id", bus_a.rsp_id_o, 1);
            chk("t4_data", bus_a.rsp_data_o, d1 ^ MASK);
            chk("t4_ready", bus_a.req_ready_o, 0);
        end
        step();
        bus_a.rsp_ready_i = 1'b1;
        wait_grants(2, 20);
        chk("t4_next", q_gnt[1], 2);
        chk("t4_gap", q_gcyc[1] - q_hcyc[0], 1);
        wait_idle(20);

        // 5. Reset while waiting on the datapath.
        clear_log();
        set_req(3, rnd128());
        wait_grants(1, 20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rsp_valid", bus_a.rsp_valid_o, 0);
        chk("t5_rsp_id", bus_a.rsp_id_o, 0);
        chk("t5_rsp_data", bus_a.rsp_data_o, 0);
        chk("t5_dp_data", dp_o_a, 0);
        chk("t5_busy", busy_a, 0);
        step();
        set_req(2, rnd128());
        set_req(0, rnd128());
        wait_grants(2, 20);
        chk("t5_grant", q_gnt[1], 0);
        chk("t5_no_rsp", q_rcyc.size(), 0);
        wait_grants(3, 40);
        wait_idle(20);

        // Random traffic with occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            bus_a.rsp_ready_i = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if (!bus_a.req_valid_i[k]) begin
                    if ($urandom_range(0, 3) == 0) set_req(k, rnd128());
                end else if ($urandom_range(0, 15) == 0) begin
                    bus_a.req_valid_i[k] = 1'b0;
                end
            end
        end
        step();
        rst = 1'b0;
        bus_a.req_valid_i = '0;
        bus_a.rsp_ready_i = 1'b1;
        wait_idle(40);

        // 6. Single-requester build with a combinational datapath.
        for (int t = 0; t < 3; t++) begin
            db = (t == 0) ? DW'(5) : rnd128();
            @(posedge clk); #2;
            bus_b.req_data_i  = db;
            bus_b.req_valid_i = 1'b1;
            bus_b.rsp_ready_i = 1'b1;
            @(negedge clk);
            chk("t6_ready", bus_b.req_ready_o, 1);
            @(posedge clk); #2;
            bus_b.req_valid_i = 1'b0;
            @(negedge clk);
            chk("t6_wait_valid", bus_b.rsp_valid_o, 0);
            chk("t6_wait_busy", busy_b, 1);
            @(posedge clk); #2;
            @(negedge clk);
            chk("t6_rsp_valid", bus_b.rsp_valid_o, 1);
            chk("t6_rsp_data", bus_b.rsp_data_o, db ^ MASK);
            chk("t6_rsp_id", bus_b.rsp_id_o, 0);
            @(posedge clk); #2;
            @(negedge clk);
            chk("t6_done_valid", bus_b.rsp_valid_o, 0);
            chk("t6_done_busy", busy_b, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
